// File: rtl/branch_resolve_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_ctrl_pkg
// Description : Shared constants and types for the branch resolve controller.
//               Holds the operand/PC width, the branch-type encoding and the
//               controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_ctrl_pkg;

    // Operand and PC width shared by decode, fetch and the controller
    localparam int BUS_WIDTH = 32;

    // Branch condition encoding as presented by decode
    typedef enum logic [2:0] {
        BR_EQ     = 3'd0,
        BR_NE     = 3'd1,
        BR_NEVER  = 3'd2,
        BR_ALWAYS = 3'd3,
        BR_LT     = 3'd4,
        BR_GE     = 3'd5,
        BR_LTU    = 3'd6,
        BR_GEU    = 3'd7
    } br_type_e;

    // Controller state encoding
    typedef logic [1:0] brc_state_t;
    localparam brc_state_t c_ST_IDLE     = 2'd0;
    localparam brc_state_t c_ST_EVAL     = 2'd1;
    localparam brc_state_t c_ST_REDIRECT = 2'd2;
    localparam brc_state_t c_ST_FLUSH    = 2'd3;

endpackage : branch_resolve_ctrl_pkg
`default_nettype wire

// File: rtl/branch_resolve_ctrl_cmp.sv
`default_nettype none
// ============================================================================
// Module      : branch_cmp
// Description : Combinational branch condition evaluator. Signed compares for
//               BR_LT/BR_GE, unsigned for BR_LTU/BR_GEU.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cmp
    import branch_resolve_ctrl_pkg::*;
(
    input  logic [2:0]           i_type,
    input  logic [BUS_WIDTH-1:0] i_a,
    input  logic [BUS_WIDTH-1:0] i_b,
    output logic                 o_taken
);

    // Decode the branch condition into the actual taken outcome
    always_comb begin
        o_taken = 1'b0;
        case (br_type_e'(i_type))
            BR_EQ:     o_taken = (i_a == i_b);
            BR_NE:     o_taken = (i_a != i_b);
            BR_NEVER:  o_taken = 1'b0;
            BR_ALWAYS: o_taken = 1'b1;
            BR_LT:     o_taken = ($signed(i_a) <  $signed(i_b));
            BR_GE:     o_taken = ($signed(i_a) >= $signed(i_b));
            BR_LTU:    o_taken = (i_a <  i_b);
            BR_GEU:    o_taken = (i_a >= i_b);
            default:   o_taken = 1'b0;
        endcase
    end

endmodule : branch_cmp
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_ctrl
// Description : Resolves one in-flight branch at a time. Latches the branch
//               from decode, evaluates it, reports the outcome and, on a
//               mispredict, issues a held redirect to fetch followed by a
//               FLUSH_CYCLES-long flush window. kill aborts in any state.
//               Optional macro BR_STATS_EN adds saturating branch/mispredict
//               counters (stat_branches, stat_mispred).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
`ifdef BR_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 br_valid,
    output logic                 br_ready,
    input  logic [2:0]           br_type,
    input  logic [BUS_WIDTH-1:0] br_a,
    input  logic [BUS_WIDTH-1:0] br_b,
    input  logic [BUS_WIDTH-1:0] br_pc,
    input  logic [BUS_WIDTH-1:0] br_target,
    input  logic                 br_pred_taken,
    input  logic                 kill,
    output logic                 resolve_valid,
    output logic                 resolve_taken,
    output logic                 redirect_valid,
    input  logic                 redirect_ready,
    output logic [BUS_WIDTH-1:0] redirect_pc,
    output logic                 flush
`ifdef BR_STATS_EN
    ,
    output logic [CNT_W-1:0]     stat_branches,
    output logic [CNT_W-1:0]     stat_mispred
`endif
);

    // Counter only needs to hold FLUSH_CYCLES-1
    localparam int c_FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    brc_state_t           r_state;
    brc_state_t           w_state_nxt;
    logic [2:0]           r_type;
    logic [BUS_WIDTH-1:0] r_a;
    logic [BUS_WIDTH-1:0] r_b;
    logic [BUS_WIDTH-1:0] r_pc;
    logic [BUS_WIDTH-1:0] r_target;
    logic                 r_pred;
    logic [BUS_WIDTH-1:0] r_redirect_pc;
    logic [c_FCNT_W-1:0]  r_flush_cnt;

    logic                 w_accept;
    logic                 w_taken;
    logic                 w_mispred;
    logic                 w_enter_redirect;
    logic                 w_redirect_hs;
    logic [BUS_WIDTH-1:0] w_redirect_pc_nxt;

    branch_cmp u_cmp (
        .i_type  (r_type),
        .i_a     (r_a),
        .i_b     (r_b),
        .o_taken (w_taken)
    );

    // kill suppresses every handshake and pulse in the cycle it is seen
    assign br_ready       = (r_state == c_ST_IDLE) && !kill;
    assign w_accept       = br_valid && br_ready;
    assign resolve_valid  = (r_state == c_ST_EVAL) && !kill;
    assign resolve_taken  = resolve_valid && w_taken;
    assign redirect_valid = (r_state == c_ST_REDIRECT) && !kill;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = (r_state == c_ST_FLUSH) && !kill;

    assign w_mispred         = (w_taken != r_pred);
    assign w_enter_redirect  = resolve_valid && w_mispred;
    assign w_redirect_hs     = redirect_valid && redirect_ready;
    // r_target is stored with bit 0 already cleared
    assign w_redirect_pc_nxt = w_taken ? r_target : (r_pc + BUS_WIDTH'(4));

    // Next-state selection; kill forces a return to IDLE from anywhere
    always_comb begin
        w_state_nxt = r_state;
        if (kill) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:     if (w_accept) w_state_nxt = c_ST_EVAL;
                c_ST_EVAL:     w_state_nxt = w_mispred ? c_ST_REDIRECT : c_ST_IDLE;
                c_ST_REDIRECT: if (redirect_ready) w_state_nxt = c_ST_FLUSH;
                c_ST_FLUSH:    if (r_flush_cnt == '0) w_state_nxt = c_ST_IDLE;
                default:       w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // State register and branch operand capture at the decode handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_type   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_pc     <= '0;
            r_target <= '0;
            r_pred   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_type   <= br_type;
                r_a      <= br_a;
                r_b      <= br_b;
                r_pc     <= br_pc;
                r_target <= br_target & ~BUS_WIDTH'(1);
                r_pred   <= br_pred_taken;
            end
        end
    end

    // Corrected PC is captured on mispredict and held through the redirect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_redirect_pc <= '0;
        end else if (w_enter_redirect) begin
            r_redirect_pc <= w_redirect_pc_nxt;
        end
    end

    // Flush window length counter, loaded at the redirect handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
        end else if (w_redirect_hs) begin
            r_flush_cnt <= c_FCNT_W'(FLUSH_CYCLES - 1);
        end else if (flush && (r_flush_cnt != '0)) begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
        end
    end

`ifdef BR_STATS_EN
    logic [CNT_W-1:0] r_stat_branches;
    logic [CNT_W-1:0] r_stat_mispred;

    // Saturating statistics; killed branches never reach resolve_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_branches <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (resolve_valid && (r_stat_branches != '1)) begin
                r_stat_branches <= r_stat_branches + 1'b1;
            end
            if (w_enter_redirect && (r_stat_mispred != '1)) begin
                r_stat_mispred <= r_stat_mispred + 1'b1;
            end
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_mispred  = r_stat_mispred;
`endif

endmodule : branch_resolve_ctrl
`default_nettype wire
